// File: rtl/uart_sched_pkg.sv
// Shared types, default sizes and the round-robin pick helper for the UART
// transmit scheduler.
//   state_t    : scheduler FSM state encoding
//   rr_pick_t  : winner index plus valid flag returned by rr_pick()
//   rr_pick()  : first requester after 'last', scanning modulo num_src
package uart_sched_pkg;

  localparam int unsigned NUM_SRC_DEF = 4;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned LEN_W_DEF   = 3;
  localparam int unsigned BUSY_TO_DEF = 15;

  // Upper bound on sources; indices are always carried at this width.
  localparam int unsigned MAX_SRC = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    NEXT      = 3'd4,
    DONE      = 3'd5
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // Scan last+1, last+2, ... (mod num_src) and return the first requester.
  function automatic rr_pick_t rr_pick(input logic [MAX_SRC-1:0] req,
                                       input logic [IDX_W-1:0]   last,
                                       input int unsigned        num_src);
    rr_pick_t    pick;
    int unsigned pos;
    pick = '0;
    for (int unsigned k = 1; k <= MAX_SRC; k++) begin
      pos = (32'(last) + k) % num_src;
      if (k <= num_src && !pick.valid && req[pos[IDX_W-1:0]]) begin
        pick.valid = 1'b1;
        pick.idx   = pos[IDX_W-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational winner selection rotated from the
// registered last-winner pointer; the pointer moves only when update_i is set.
//   clk, reset     : clock, async active-low reset (pointer -> NUM_SRC-1)
//   req_i          : request vector
//   update_i       : commit the current winner as the new 'last'
//   win_valid_c_o  : some request is pending (combinational)
//   win_idx_c_o    : index of the winner (combinational)
module rr_arbiter
  import uart_sched_pkg::*;
#(
  parameter int unsigned NUM_SRC = NUM_SRC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] req_i,
  input  logic               update_i,
  output logic               win_valid_c_o,
  output logic [IDX_W-1:0]   win_idx_c_o
);

  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] last_d;
  rr_pick_t         pick_c;

  // Rotate priority so the source after the last winner is scanned first.
  always_comb begin
    pick_c = rr_pick(MAX_SRC'(req_i), last_q, NUM_SRC);
    last_d = last_q;
    if (update_i && pick_c.valid) begin
      last_d = pick_c.idx;
    end
  end

  assign win_valid_c_o = pick_c.valid;
  assign win_idx_c_o   = pick_c.idx;

  // Reset pointer to the highest index so source 0 wins first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= IDX_W'(NUM_SRC - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one byte-wide UART transmitter among NUM_SRC sources. A round-robin
// winner owns the UART for its whole burst; every byte is sent with a
// start strobe followed by a wait for the UART busy pulse (or a timeout).
//   clk, reset : clock, async active-low reset
//   src_req    : per-source level request, held until src_done
//   src_len    : per-source burst length, source i at [i*LEN_W +: LEN_W]
//   src_data   : per-source byte at byte_idx, source i at [i*DATA_W +: DATA_W]
//   grant      : one-hot transmitter owner, zero when idle
//   byte_idx   : byte currently requested from the granted source
//   src_done   : one-cycle pulse to the source whose burst finished
//   tx_data    : granted source's byte (combinational), zero when idle
//   tx_start   : one-cycle send strobe to the UART
//   tx_busy    : UART busy, high while a byte is shifting out
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int unsigned NUM_SRC = NUM_SRC_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned LEN_W   = LEN_W_DEF,
  parameter int unsigned BUSY_TO = BUSY_TO_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        src_req,
  input  logic [NUM_SRC*LEN_W-1:0]  src_len,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [NUM_SRC-1:0]        grant,
  output logic [LEN_W-1:0]          byte_idx,
  output logic [NUM_SRC-1:0]        src_done,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_start,
  input  logic                      tx_busy
);

  localparam int unsigned CNT_W = (BUSY_TO < 1) ? 1 : $clog2(BUSY_TO + 1);

  state_t               state_q, state_d;
  logic [NUM_SRC-1:0]   grant_q, grant_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     byte_idx_q, byte_idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_SRC-1:0]   src_done_q, src_done_d;
  logic                 tx_start_q, tx_start_d;

  logic                 win_valid_c;
  logic [IDX_W-1:0]     win_idx_c;
  logic                 arb_update_c;
  logic [NUM_SRC-1:0]   win_oh_c;
  logic [LEN_W-1:0]     win_len_c;
  logic [DATA_W-1:0]    tx_data_c;

  rr_arbiter #(
    .NUM_SRC(NUM_SRC)
  ) u_arb (
    .clk          (clk),
    .reset        (reset),
    .req_i        (src_req),
    .update_i     (arb_update_c),
    .win_valid_c_o(win_valid_c),
    .win_idx_c_o  (win_idx_c)
  );

  // One-hot winner, its length, and the granted source's byte (AND-OR muxes).
  always_comb begin
    win_oh_c  = NUM_SRC'(1) << win_idx_c;
    win_len_c = '0;
    tx_data_c = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (win_oh_c[i]) begin
        win_len_c = win_len_c | src_len[i*LEN_W +: LEN_W];
      end
      if (grant_q[i]) begin
        tx_data_c = tx_data_c | src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    len_d        = len_q;
    byte_idx_d   = byte_idx_q;
    cnt_d        = cnt_q;
    arb_update_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (win_valid_c) begin
          arb_update_c = 1'b1;
          grant_d      = win_oh_c;
          len_d        = win_len_c;
          byte_idx_d   = '0;
          state_d      = (win_len_c == '0) ? DONE : START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // A UART that never raises busy must not stall the burst.
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_W'(BUSY_TO)) begin
          state_d = NEXT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (byte_idx_q == len_q - 1'b1) begin
          state_d = DONE;
        end else begin
          byte_idx_d = byte_idx_q + 1'b1;
          state_d    = START;
        end
      end
      DONE: begin
        grant_d    = '0;
        byte_idx_d = '0;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Strobes are registered so they coincide with the START/DONE cycles.
    tx_start_d = (state_d == START);
    src_done_d = (state_d == DONE) ? grant_d : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      len_q      <= '0;
      byte_idx_q <= '0;
      cnt_q      <= '0;
      src_done_q <= '0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      len_q      <= len_d;
      byte_idx_q <= byte_idx_d;
      cnt_q      <= cnt_d;
      src_done_q <= src_done_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign grant    = grant_q;
  assign byte_idx = byte_idx_q;
  assign src_done = src_done_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_c;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: a UART responder model, sources
// that serve bytes from per-source tables, and a transaction-level reference
// model (round-robin service order and expected byte stream).
module tb_uart_tx_scheduler;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned LEN_W   = 3;
  localparam int unsigned BUSY_TO = 15;
  localparam int          BUDGET  = 4000;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_SRC-1:0]        src_req;
  logic [NUM_SRC*LEN_W-1:0]  src_len;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        grant;
  logic [LEN_W-1:0]          byte_idx;
  logic [NUM_SRC-1:0]        src_done;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_start;
  logic                      tx_busy;

  logic [DATA_W-1:0] tbl [NUM_SRC][8];
  int                lens [NUM_SRC];

  // UART model knobs
  int busy_dly = 1;
  int busy_len = 3;
  bit uart_en  = 1'b1;

  // Observed events
  int          ev_src  [$];
  logic [7:0]  ev_byte [$];
  int          ev_idx  [$];
  int          done_q  [$];
  int          cyc = 0;
  int          start_cyc = 0;
  int          done_cyc = 0;

  // Reference model state
  int          model_last = NUM_SRC - 1;
  int          exp_src  [$];
  logic [7:0]  exp_byte [$];
  int          exp_idx  [$];

  int errors = 0;
  int checks = 0;

  uart_tx_scheduler #(
    .NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .LEN_W(LEN_W), .BUSY_TO(BUSY_TO)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .src_req (src_req),
    .src_len (src_len),
    .src_data(src_data),
    .grant   (grant),
    .byte_idx(byte_idx),
    .src_done(src_done),
    .tx_data (tx_data),
    .tx_start(tx_start),
    .tx_busy (tx_busy)
  );

  always #5 clk = ~clk;

  // Sources present the table byte selected by byte_idx.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_data[i*DATA_W +: DATA_W] = tbl[i][byte_idx];
    end
  end

  // UART: after a start strobe, raise busy after busy_dly cycles for busy_len.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && uart_en) begin
        repeat (busy_dly) @(negedge clk);
        tx_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int oh_idx(input logic [NUM_SRC-1:0] v);
    int r = -1;
    for (int i = NUM_SRC - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  // Advance one cycle, sample outputs at the negedge, record events.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (tx_start) begin
      ev_src.push_back(oh_idx(grant));
      ev_byte.push_back(tx_data);
      ev_idx.push_back(int'(byte_idx));
      start_cyc = cyc;
    end
    if (src_done != '0) begin
      check("done_matches_grant", 32'(src_done), 32'(grant));
      done_q.push_back(oh_idx(src_done));
      done_cyc = cyc;
      src_req = src_req & ~src_done;
    end
  endtask

  task automatic clear_obs();
    ev_src = {}; ev_byte = {}; ev_idx = {}; done_q = {};
  endtask

  task automatic wait_ev(input int n, input string tag);
    int b = 0;
    while (ev_src.size() < n && b < BUDGET) begin step(); b++; end
    check(tag, 32'(ev_src.size() >= n), 32'd1);
  endtask

  task automatic wait_done(input int n, input string tag);
    int b = 0;
    while (done_q.size() < n && b < BUDGET) begin step(); b++; end
    check(tag, 32'(done_q.size() >= n), 32'd1);
  endtask

  task automatic load_lens();
    for (int i = 0; i < NUM_SRC; i++) src_len[i*LEN_W +: LEN_W] = LEN_W'(lens[i]);
  endtask

  // All sources in mask request together; the model predicts order and bytes.
  task automatic run_batch(input logic [NUM_SRC-1:0] mask);
    int order [$];
    int pos;
    int n;
    step();
    pos = model_last;
    for (int k = 0; k < NUM_SRC; k++) begin
      pos = (pos + 1) % NUM_SRC;
      if (mask[pos]) order.push_back(pos);
    end
    exp_src = {}; exp_byte = {}; exp_idx = {};
    foreach (order[j]) begin
      for (int k = 0; k < lens[order[j]]; k++) begin
        exp_src.push_back(order[j]);
        exp_byte.push_back(tbl[order[j]][k]);
        exp_idx.push_back(k);
      end
    end
    load_lens();
    clear_obs();
    src_req = mask;
    step();
    check("grant_next_cycle", 32'(grant), 32'(1) << order[0]);
    wait_done(order.size(), "batch_completes");
    check("done_count", 32'(done_q.size()), 32'(order.size()));
    n = (done_q.size() < order.size()) ? done_q.size() : order.size();
    for (int j = 0; j < n; j++) check("done_order", 32'(done_q[j]), 32'(order[j]));
    check("byte_count", 32'(ev_src.size()), 32'(exp_src.size()));
    n = (ev_src.size() < exp_src.size()) ? ev_src.size() : exp_src.size();
    for (int j = 0; j < n; j++) begin
      check("byte_src", 32'(ev_src[j]), 32'(exp_src[j]));
      check("byte_data", 32'(ev_byte[j]), 32'(exp_byte[j]));
      check("byte_idx", 32'(ev_idx[j]), 32'(exp_idx[j]));
    end
    step();
    check("grant_released", 32'(grant), 32'd0);
    model_last = order[order.size() - 1];
  endtask

  task automatic rand_tables();
    for (int i = 0; i < NUM_SRC; i++)
      for (int k = 0; k < 8; k++) tbl[i][k] = 8'($urandom);
  endtask

  initial begin
    reset   = 1'b0;
    src_req = '0;
    src_len = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      lens[i] = 0;
      for (int k = 0; k < 8; k++) tbl[i][k] = '0;
    end

    // Reset values
    step(); step();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_byte_idx", 32'(byte_idx), 32'd0);
    check("rst_src_done", 32'(src_done), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    reset = 1'b1;
    step();

    // Sources 0 and 2 together, twice: 0 before 2 both times
    rand_tables();
    busy_dly = 1; busy_len = 3;
    lens = '{1, 0, 1, 0};
    run_batch(4'b0101);
    run_batch(4'b0101);

    // Source 1, two bytes, 10-cycle UART busy
    tbl[1][0] = 8'hA5; tbl[1][1] = 8'h3C;
    busy_len = 10;
    lens = '{0, 2, 0, 0};
    run_batch(4'b0010);

    // Source 3 with zero length: grant and done only
    lens = '{0, 0, 0, 0};
    run_batch(4'b1000);

    // UART never goes busy: byte times out
    uart_en = 1'b0;
    lens = '{1, 0, 0, 0};
    run_batch(4'b0001);
    check("timeout_latency", 32'(done_cyc - start_cyc), 32'(BUSY_TO + 3));
    uart_en = 1'b1;

    // Randomized batches
    for (int r = 0; r < 15; r++) begin
      rand_tables();
      busy_dly = $urandom_range(0, 3);
      busy_len = $urandom_range(1, 6);
      for (int i = 0; i < NUM_SRC; i++) lens[i] = $urandom_range(0, 7);
      run_batch(NUM_SRC'($urandom_range(1, (1 << NUM_SRC) - 1)));
    end

    // Reset while the second byte of a 3-byte burst is shifting out
    rand_tables();
    busy_dly = 0; busy_len = 20;
    lens = '{0, 3, 0, 0};
    load_lens();
    step();
    clear_obs();
    src_req = 4'b0010;
    wait_ev(2, "rst_reach_byte1");
    repeat (3) step();
    reset = 1'b0;
    #1;
    check("midrst_grant", 32'(grant), 32'd0);
    check("midrst_byte_idx", 32'(byte_idx), 32'd0);
    check("midrst_tx_start", 32'(tx_start), 32'd0);
    check("midrst_src_done", 32'(src_done), 32'd0);
    check("midrst_tx_data", 32'(tx_data), 32'd0);
    src_req = '0;
    done_q = {};
    for (int b = 0; b < 40 && tx_busy; b++) step();
    step();
    check("midrst_no_done", 32'(done_q.size()), 32'd0);
    reset = 1'b1;
    model_last = NUM_SRC - 1;
    busy_len = 3;
    lens = '{2, 1, 0, 0};
    run_batch(4'b0011);

    // Source 2 streams while source 0 requests mid-burst
    rand_tables();
    busy_dly = 1; busy_len = 4;
    lens = '{1, 0, 4, 0};
    load_lens();
    step();
    clear_obs();
    src_req = 4'b0100;
    step();
    check("stream_grant2", 32'(grant), 32'b0100);
    wait_ev(2, "stream_reach_byte1");
    src_req[0] = 1'b1;
    wait_done(1, "stream_src2_done");
    check("stream_first_done", (done_q.size() > 0) ? 32'(done_q[0]) : 32'hFFFF_FFFF, 32'd2);
    step();
    check("stream_idle_gap", 32'(grant), 32'd0);
    step();
    check("stream_grant0", 32'(grant), 32'b0001);
    wait_done(2, "stream_src0_done");
    check("stream_second_done", (done_q.size() > 1) ? 32'(done_q[1]) : 32'hFFFF_FFFF, 32'd0);
    check("stream_byte_count", 32'(ev_src.size()), 32'd5);
    if (ev_src.size() == 5) begin
      for (int k = 0; k < 4; k++) begin
        check("stream_src2_owner", 32'(ev_src[k]), 32'd2);
        check("stream_src2_byte", 32'(ev_byte[k]), 32'(tbl[2][k]));
      end
      check("stream_src0_owner", 32'(ev_src[4]), 32'd0);
      check("stream_src0_byte", 32'(ev_byte[4]), 32'(tbl[0][0]));
    end
    step();
    check("stream_grant_released", 32'(grant), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one byte-wide UART transmitter among NUM_SRC result producers, such as the MxV result senders.
- Arbitrates round-robin between sources. The winner keeps the transmitter for a complete burst of up to 2^LEN_W-1 bytes.
- Sequences each byte with a proper start/busy handshake instead of fixed rest delays.
- Sits between the compute/result blocks and the UART TX core.

Parameters:
- NUM_SRC, 4: number of requesting sources (2..8).
- DATA_W, 8: byte width.
- LEN_W, 3: width of the per-source burst length, so the maximum burst is 7 bytes.
- BUSY_TO, 15: cycles to wait for tx_busy to rise after tx_start before the byte is treated as sent.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- src_req  in  NUM_SRC  level request per source; held until that source's src_done
- src_len  in  NUM_SRC*LEN_W  burst length per source, packed with source i at [i*LEN_W +: LEN_W]
- src_data  in  NUM_SRC*DATA_W  byte at the current byte_idx per source, packed the same way
- grant  out  NUM_SRC  one-hot owner of the transmitter; all zero when idle
- byte_idx  out  LEN_W  index of the byte currently requested from the granted source
- src_done  out  NUM_SRC  one-cycle pulse to the source whose burst just finished
- tx_data  out  DATA_W  byte to the UART
- tx_start  out  1  one-cycle send strobe to the UART
- tx_busy  in  1  UART busy; high while a byte is shifting out

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - grant=0, byte_idx=0, src_done=0, tx_start=0, tx_data=0;
  - state=IDLE; round-robin pointer last=NUM_SRC-1, so source 0 wins first.
- States: IDLE, START, WAIT_BUSY, WAIT_DONE, NEXT, DONE.
- IDLE:
  - If any src_req is set, select the first requester scanning last+1, last+2, … modulo NUM_SRC.
  - Register the winner into grant, its length into len_q, byte_idx=0, and last=winner.
  - If len==0, go to DONE; otherwise go to START.
  - grant is visible one cycle after the request is seen.
- START:
  - tx_start=1 for exactly one cycle. Go to WAIT_BUSY and clear the timeout counter.
- WAIT_BUSY:
  - If tx_busy=1, go to WAIT_DONE.
  - Else if the counter reaches BUSY_TO, go to NEXT (byte is considered sent).
  - Otherwise increment the counter.
- WAIT_DONE:
  - Stay while tx_busy=1. When tx_busy=0, go to NEXT.
- NEXT:
  - If byte_idx==len_q-1, go to DONE.
  - Otherwise byte_idx++ and go to START.
  - This gives at least one idle cycle between bytes.
- DONE:
  - src_done[winner]=1 for one cycle, grant cleared, byte_idx=0, return to IDLE.
  - The released source is eligible again only after the others have been scanned.
- tx_data:
  - Combinationally the granted source's src_data slice while grant≠0; 0 in IDLE.
  - Sources must hold src_data stable while byte_idx is unchanged.
- Length handling:
  - len_q is captured at grant time. Later src_len changes are ignored until the next grant.
- Request withdrawal:
  - A request dropped mid-burst does not abort the burst. It completes and src_done still pulses.
- Simultaneous events:
  - New requests arriving during a burst wait.
  - A source whose req is still high in the cycle after src_done is treated as a new request.
- tx_busy edge cases:
  - tx_busy already high in START is ignored; only WAIT_BUSY samples it.
  - Busy stuck high holds WAIT_DONE indefinitely; there is no timeout there.
- Reset mid-burst: immediate return to the reset values; no src_done pulse.
- Per-byte latency: START to NEXT is 2 + UART busy time; 2 + BUSY_TO cycles on timeout.

Decomposition:
- Package uart_sched_pkg holds:
  - the state enum typedef state_t (logic [2:0]);
  - the default NUM_SRC/DATA_W/LEN_W constants;
  - the helper function rr_pick(req, last), returning the winner index and a valid flag.
- One sub-module, rr_arbiter:
  - combinational priority rotation plus the registered last pointer, enabled by an update input;
  - parameterised by NUM_SRC.

Test Plan:
- Source 1, len=2, bytes 0xA5, 0x3C; UART busy 10 cycles per byte.
  - grant=0010 one cycle after req.
  - Two tx_start pulses carrying 0xA5 then 0x3C.
  - byte_idx 0→1; src_done[1] pulses once; grant returns to 0.
- src_req=0101 asserted together, each len=1.
  - Source 0 served first, then source 2.
  - Re-asserting 0101 after both finish: source 0 is served before source 2 again (pointer wrapped past 2).
- Source 3, len=0.
  - grant=1000 for one cycle, src_done[3] pulse, no tx_start.
- tx_busy held 0, len=1.
  - tx_start once; src_done after exactly BUSY_TO+1 WAIT_BUSY cycles; no hang.
- reset pulled low during WAIT_DONE of byte 1 of a 3-byte burst.
  - All outputs 0 immediately, no src_done.
  - After release, source 0 wins a fresh request.
- Source 2 streaming while source 0 requests mid-burst.
  - Source 2 finishes all bytes uninterrupted; source 0 is granted in the cycle after IDLE.
